// File: rtl/router_rx_port.sv
// router_rx_port: consumer for one router output port. Waits a short delay
// after vld_out rises, then reads header, payload and parity. The payload is
// streamed to a local sink, and address and parity status is reported once
// per packet. A packet that stalls for too long with data pending is dropped
// and flagged with a lost pulse.
//
// state | meaning
// IDLE  | no packet in progress, waiting for vld_out
// DLY   | start delay after vld_out rises, before the first read
// RD    | issuing reads and consuming header / payload / parity
// DONE  | one-cycle status report, then idle or the next packet
module router_rx_port #(
  parameter logic [1:0] PORT_ID   = 2'd0,
  parameter int         START_DLY = 4,
  parameter int         TMO_LIMIT = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       rx_hold,
  output logic       re,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       par_err,
  output logic       addr_err,
  output logic       lost
);

  typedef enum logic [1:0] {S_IDLE, S_DLY, S_RD, S_DONE} state_t;

  localparam logic [4:0] DLY_LOAD = 5'(START_DLY);
  localparam logic [4:0] TMO_TC   = 5'(TMO_LIMIT);

  state_t     state_q, state_d;
  logic [4:0] dly_q, dly_d;
  logic [6:0] iss_q, iss_d;
  logic [6:0] rcv_q, rcv_d;
  logic [4:0] tmo_q, tmo_d;
  logic [5:0] len_q, len_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] xor_q, xor_d;
  logic       hdr_q, hdr_d;
  logic       pend_q, pend_d;
  logic [7:0] pl_data_q, pl_data_d;
  logic       pl_valid_q, pl_valid_d;
  logic [5:0] pkt_len_q, pkt_len_d;
  logic       par_err_q, par_err_d;
  logic       addr_err_q, addr_err_d;
  logic       lost_q, lost_d;

  logic [6:0] limit;
  logic       issue;

  // Until the header is seen only header plus one more byte may be read;
  // afterwards the exact packet length bounds the reads.
  assign limit = hdr_q ? ({1'b0, len_q} + 7'd2) : 7'd2;

  // Read enable: only while reading, data present, sink ready, reads remaining.
  always_comb begin
    re = (state_q == S_RD) & vld_out & ~rx_hold & (iss_q < limit);
  end

  assign issue = re & vld_out;

  // Next-state, counters, byte consumption and status.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    tmo_d      = tmo_q;
    len_d      = len_q;
    addr_d     = addr_q;
    xor_d      = xor_q;
    hdr_d      = hdr_q;
    pend_d     = 1'b0;
    pl_data_d  = pl_data_q;
    pl_valid_d = 1'b0;
    pkt_len_d  = pkt_len_q;
    par_err_d  = par_err_q;
    addr_err_d = addr_err_q;
    lost_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vld_out) begin
          state_d = S_DLY;
          dly_d   = DLY_LOAD;
          tmo_d   = 5'd0;
        end
      end
      S_DLY: begin
        if (vld_out) tmo_d = tmo_q + 5'd1;
        if (dly_q == 5'd0) state_d = S_RD;
        else               dly_d   = dly_q - 5'd1;
      end
      S_RD: begin
        pend_d = issue;
        if (issue) begin
          iss_d = iss_q + 7'd1;
          tmo_d = 5'd0;
        end else if (vld_out) begin
          tmo_d = tmo_q + 5'd1;
        end
        // data_out carries the byte read in the previous cycle
        if (pend_q) begin
          if (rcv_q == 7'd0) begin
            len_d  = data_out[7:2];
            addr_d = data_out[1:0];
            xor_d  = data_out;
            hdr_d  = 1'b1;
            rcv_d  = 7'd1;
          end else if (rcv_q <= {1'b0, len_q}) begin
            pl_data_d  = data_out;
            pl_valid_d = 1'b1;
            xor_d      = xor_q ^ data_out;
            rcv_d      = rcv_q + 7'd1;
          end else begin
            pkt_len_d  = len_q;
            par_err_d  = (xor_q != data_out);
            addr_err_d = (addr_q != PORT_ID);
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        iss_d  = 7'd0;
        rcv_d  = 7'd0;
        tmo_d  = 5'd0;
        hdr_d  = 1'b0;
        xor_d  = 8'd0;
        len_d  = 6'd0;
        addr_d = 2'd0;
        if (vld_out) begin
          state_d = S_DLY;
          dly_d   = DLY_LOAD;
        end else begin
          state_d = S_IDLE;
          dly_d   = 5'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stall abort: drop the partial packet and return to idle.
    if ((state_q == S_DLY || state_q == S_RD) && tmo_d == TMO_TC) begin
      lost_d     = 1'b1;
      state_d    = S_IDLE;
      dly_d      = 5'd0;
      iss_d      = 7'd0;
      rcv_d      = 7'd0;
      tmo_d      = 5'd0;
      hdr_d      = 1'b0;
      xor_d      = 8'd0;
      len_d      = 6'd0;
      addr_d     = 2'd0;
      pend_d     = 1'b0;
      pl_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dly_q      <= 5'd0;
      iss_q      <= 7'd0;
      rcv_q      <= 7'd0;
      tmo_q      <= 5'd0;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      xor_q      <= 8'd0;
      hdr_q      <= 1'b0;
      pend_q     <= 1'b0;
      pl_data_q  <= 8'd0;
      pl_valid_q <= 1'b0;
      pkt_len_q  <= 6'd0;
      par_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      tmo_q      <= tmo_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      xor_q      <= xor_d;
      hdr_q      <= hdr_d;
      pend_q     <= pend_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pkt_len_q  <= pkt_len_d;
      par_err_q  <= par_err_d;
      addr_err_q <= addr_err_d;
      lost_q     <= lost_d;
    end
  end

  assign pl_data  = pl_data_q;
  assign pl_valid = pl_valid_q;
  assign pkt_done = (state_q == S_DONE);
  assign pkt_len  = pkt_len_q;
  assign par_err  = par_err_q;
  assign addr_err = addr_err_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: a router-port model (byte FIFO) feeds the DUT and
// a packet-level scoreboard checks streamed payload and per-packet status.
module tb_router_rx_port;

  logic       clk, rst, vld_out, rx_hold;
  logic [7:0] data_out;
  logic       re, pl_valid, pkt_done, par_err, addr_err, lost;
  logic [7:0] pl_data;
  logic [5:0] pkt_len;

  router_rx_port #(.PORT_ID(2'd0), .START_DLY(4), .TMO_LIMIT(29)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .data_out(data_out),
    .rx_hold(rx_hold), .re(re), .pl_data(pl_data), .pl_valid(pl_valid),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .par_err(par_err),
    .addr_err(addr_err), .lost(lost)
  );

  typedef struct packed {
    logic [5:0] len;
    logic       par;
    logic       addr;
  } st_t;

  logic [7:0] fifo[$];
  logic [7:0] exp_pl[$];
  st_t        exp_st[$];
  int checks = 0, errors = 0;
  int pl_cnt = 0, done_cnt = 0, lost_cnt = 0;
  logic re_s, lost_s;
  logic [5:0] last_len;
  logic last_par, last_addr;
  bit pause = 0, rand_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_re"}, 32'(re), 0);
    chk({tag, "_pl_data"}, 32'(pl_data), 0);
    chk({tag, "_pl_valid"}, 32'(pl_valid), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 0);
    chk({tag, "_par_err"}, 32'(par_err), 0);
    chk({tag, "_addr_err"}, 32'(addr_err), 0);
    chk({tag, "_lost"}, 32'(lost), 0);
  endtask

  // Packet model: header, len payload bytes, parity byte.
  task automatic push_raw(input logic [7:0] b[$]);
    logic [7:0] x;
    int len;
    st_t s;
    len = int'(b[0][7:2]);
    x = b[0];
    for (int i = 1; i <= len; i++) begin
      exp_pl.push_back(b[i]);
      x ^= b[i];
    end
    s.len  = b[0][7:2];
    s.par  = (x != b[len+1]);
    s.addr = (b[0][1:0] != 2'd0);
    exp_st.push_back(s);
    foreach (b[i]) fifo.push_back(b[i]);
    vld_out = (fifo.size() != 0) && !pause;
  endtask

  task automatic push_rand(input logic [7:0] hdr, input bit corrupt);
    logic [7:0] b[$];
    logic [7:0] x;
    logic [7:0] v;
    b.push_back(hdr);
    x = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      v = 8'($urandom);
      b.push_back(v);
      x ^= v;
    end
    if (corrupt) x ^= 8'(1 << $urandom_range(0, 7));
    b.push_back(x);
    push_raw(b);
  endtask

  // One clock: sample outputs mid-cycle, then update the port model.
  task automatic tick();
    bit issue;
    st_t s;
    @(negedge clk);
    re_s   = re;
    lost_s = lost;
    issue  = re && vld_out;
    if (rx_hold) chk("re_under_hold", 32'(re), 0);
    if (pl_valid) begin
      pl_cnt++;
      if (exp_pl.size() == 0) chk("pl_unexpected", 1, 0);
      else chk("pl_data", 32'(pl_data), 32'(exp_pl.pop_front()));
    end
    if (pkt_done) begin
      done_cnt++;
      last_len  = pkt_len;
      last_par  = par_err;
      last_addr = addr_err;
      if (exp_st.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        s = exp_st.pop_front();
        chk("pkt_len", 32'(pkt_len), 32'(s.len));
        chk("par_err", 32'(par_err), 32'(s.par));
        chk("addr_err", 32'(addr_err), 32'(s.addr));
      end
    end
    if (lost) lost_cnt++;
    @(posedge clk);
    #1;
    if (issue) data_out = fifo.pop_front();
    else       data_out = 8'($urandom);
    if (rand_mode) begin
      rx_hold = ($urandom_range(0, 4) == 0);
      pause   = ($urandom_range(0, 9) == 0);
    end
    vld_out = (fifo.size() != 0) && !pause;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_pl(input int target, input int budget);
    int n = 0;
    while (pl_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("pl_wait", 32'(pl_cnt), 32'(target));
  endtask

  initial begin
    logic [7:0] q[$];
    int base_pl, base_d, base_l, first, n;
    logic [1:0] a;
    rst = 1'b1; vld_out = 1'b0; data_out = 8'd0; rx_hold = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    chk_zero("idle");

    // 1: good packet
    base_pl = pl_cnt; base_d = done_cnt;
    q = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    push_raw(q);
    wait_done(base_d + 1, 200);
    chk("t1_pl_count", 32'(pl_cnt - base_pl), 3);
    chk("t1_len", 32'(last_len), 3);
    chk("t1_par", 32'(last_par), 0);
    chk("t1_addr", 32'(last_addr), 0);

    // 2: bad parity, payload still streamed
    base_pl = pl_cnt; base_d = done_cnt;
    q = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_raw(q);
    wait_done(base_d + 1, 200);
    chk("t2_pl_count", 32'(pl_cnt - base_pl), 3);
    chk("t2_par", 32'(last_par), 1);

    // 3: wrong address
    base_d = done_cnt;
    q = '{8'h05, 8'hA5, 8'hA0};
    push_raw(q);
    wait_done(base_d + 1, 200);
    chk("t3_addr", 32'(last_addr), 1);
    chk("t3_len", 32'(last_len), 1);
    chk("t3_par", 32'(last_par), 0);

    // 4: rx_hold for 5 cycles mid-payload
    base_pl = pl_cnt; base_d = done_cnt; base_l = lost_cnt;
    push_rand(8'h20, 1'b0);
    wait_pl(base_pl + 3, 200);
    rx_hold = 1'b1;
    repeat (5) tick();
    rx_hold = 1'b0;
    tick();
    chk("t4_re_resume", 32'(re_s), 1);
    wait_done(base_d + 1, 200);
    chk("t4_pl_count", 32'(pl_cnt - base_pl), 8);
    chk("t4_par", 32'(last_par), 0);
    chk("t4_no_lost", 32'(lost_cnt - base_l), 0);

    // Randomized packets, back-to-back groups, random hold and vld gaps
    base_l = lost_cnt;
    rand_mode = 1;
    for (int g = 0; g < 15; g++) begin
      n = $urandom_range(1, 3);
      base_d = done_cnt;
      for (int k = 0; k < n; k++) begin
        a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        push_rand({6'($urandom_range(0, 20)), a}, $urandom_range(0, 3) == 0);
      end
      wait_done(base_d + n, 800);
    end
    rand_mode = 0; rx_hold = 1'b0; pause = 0;
    tick(); tick();
    chk("rand_no_lost", 32'(lost_cnt - base_l), 0);
    chk("rand_pl_drained", 32'(exp_pl.size()), 0);
    chk("rand_st_drained", 32'(exp_st.size()), 0);

    // 5: rx_hold stuck high -> lost after 29 stalled cycles
    base_d = done_cnt; base_l = lost_cnt; first = -1;
    rx_hold = 1'b1;
    push_rand(8'h08, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (lost_s && first < 0) begin
        first = k;
        chk("t5_re_at_lost", 32'(re_s), 0);
        fifo.delete(); exp_pl.delete(); exp_st.delete();
      end
    end
    rx_hold = 1'b0;
    chk("t5_lost_cycle", 32'(first), 30);
    chk("t5_lost_pulses", 32'(lost_cnt - base_l), 1);
    chk("t5_no_done", 32'(done_cnt - base_d), 0);

    // 6: back-to-back len=1 then len=0, then reset mid third packet
    base_d = done_cnt;
    push_rand(8'h04, 1'b0);
    push_rand(8'h00, 1'b0);
    wait_done(base_d + 2, 300);
    chk("t6_two_done", 32'(done_cnt - base_d), 2);
    base_pl = pl_cnt;
    push_rand(8'h10, 1'b0);
    wait_pl(base_pl + 2, 200);
    rst = 1'b1;
    #1;
    chk_zero("t6_async_rst");
    fifo.delete(); exp_pl.delete(); exp_st.delete();
    vld_out = 1'b0; data_out = 8'd0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk_zero("t6_after_rst");
    chk("t6_done_total", 32'(done_cnt - base_d), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
